// File: rtl/txn_pkg.sv
// Shared types and constants for the transaction input front-end.
// Holds the controller state encoding, status codes, mode values and field width.
// Combinational helper only; no timing or backpressure of its own.
package txn_pkg;

    localparam int CODE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        REJECT = 2'd2
    } state_t;

    localparam logic [1:0] STATUS_EMPTY    = 2'b00;
    localparam logic [1:0] STATUS_PARTIAL  = 2'b01;
    localparam logic [1:0] STATUS_COMPLETE = 2'b10;
    localparam logic [1:0] STATUS_REJECT   = 2'b11;

    localparam logic MODE_ADD    = 1'b1;
    localparam logic MODE_REMOVE = 1'b0;

    // Status reported while idle, derived from which fields have been captured.
    function automatic logic [1:0] status_of_flags(input logic code_ok, input logic quant_ok);
        if (code_ok && quant_ok) begin
            return STATUS_COMPLETE;
        end else if (code_ok || quant_ok) begin
            return STATUS_PARTIAL;
        end else begin
            return STATUS_EMPTY;
        end
    endfunction

endpackage

// File: rtl/txn_input_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, debounced level, one-cycle press pulse.
// Latency: raw level change to press pulse is 2 + DEBOUNCE_CYCLES cycles.
// No backpressure; press is a single-cycle event the consumer must take or drop.
// Ports: clk, rst_n (async active-low), btn_n (raw active-low button), press (pulse on 1->0).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta;
    logic             btn_sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Reset to 1 so a released button produces no spurious event after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
        end else begin
            btn_meta <= btn_n;
            btn_sync <= btn_meta;
        end
    end

    // cnt holds how many consecutive samples so far disagree with level; the
    // DEBOUNCE_CYCLES-th disagreeing sample flips the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_sync != level) begin
                if (cnt == CNT_MAX) begin
                    level <= btn_sync;
                    cnt   <= '0;
                    press <= ~btn_sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/txn_input_ctrl.sv
// Captures part code/quantity from switches and offers one validated add/remove command.
// Latency: submit event to cmd_valid 1 cycle; save event to field update 1 cycle.
// cmd_valid holds with constant payload until cmd_ready; buttons during issue are dropped.
// Ports: raw switches/buttons in, cmd_valid/cmd_ready handshake, cmd_add/code/quant, status.
module txn_input_ctrl
    import txn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_sw,
    input  logic              cq_sw,
    input  logic [CODE_W-1:0] data_sw,
    input  logic              save_btn_n,
    input  logic              submit_btn_n,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_add,
    output logic [CODE_W-1:0] cmd_code,
    output logic [CODE_W-1:0] cmd_quant,
    output logic [1:0]        status
);

    // Switch synchronizers: {mode, cq, data}
    logic [CODE_W+1:0] sw_meta;
    logic [CODE_W+1:0] sw_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= {mode_sw, cq_sw, data_sw};
            sw_sync <= sw_meta;
        end
    end

    logic              mode_s;
    logic              cq_s;
    logic [CODE_W-1:0] data_s;

    assign mode_s = sw_sync[CODE_W+1];
    assign cq_s   = sw_sync[CODE_W];
    assign data_s = sw_sync[CODE_W-1:0];

    logic save_ev;
    logic submit_ev;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_save_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (save_btn_n),
        .press (save_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_submit_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (submit_btn_n),
        .press (submit_ev)
    );

    state_t            state;
    logic [CODE_W-1:0] code_r;
    logic [CODE_W-1:0] quant_r;
    logic              code_ok;
    logic              quant_ok;
    logic              add_r;
    logic              ok_to_issue;

    // A zero quantity is never a meaningful transaction, so it is rejected here.
    assign ok_to_issue = code_ok && quant_ok && (quant_r != '0);

    // Save has priority over submit in the same cycle: the submit is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            code_r    <= '0;
            quant_r   <= '0;
            code_ok   <= 1'b0;
            quant_ok  <= 1'b0;
            add_r     <= MODE_REMOVE;
            cmd_valid <= 1'b0;
            status    <= STATUS_EMPTY;
        end else begin
            case (state)
                IDLE, REJECT: begin
                    if (save_ev) begin
                        if (cq_s) begin
                            code_r  <= data_s;
                            code_ok <= 1'b1;
                        end else begin
                            quant_r  <= data_s;
                            quant_ok <= 1'b1;
                        end
                        state  <= IDLE;
                        status <= status_of_flags(cq_s | code_ok, ~cq_s | quant_ok);
                    end else if (submit_ev) begin
                        if (ok_to_issue) begin
                            add_r     <= mode_s;
                            cmd_valid <= 1'b1;
                            state     <= ISSUE;
                            status    <= STATUS_COMPLETE;
                        end else begin
                            state  <= REJECT;
                            status <= STATUS_REJECT;
                        end
                    end
                end
                ISSUE: begin
                    // Payload registers are frozen here because saves are ignored.
                    if (cmd_ready) begin
                        code_ok   <= 1'b0;
                        quant_ok  <= 1'b0;
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                        status    <= STATUS_EMPTY;
                    end
                end
                default: begin
                    cmd_valid <= 1'b0;
                    state     <= IDLE;
                    status    <= status_of_flags(code_ok, quant_ok);
                end
            endcase
        end
    end

    assign cmd_add   = add_r;
    assign cmd_code  = code_r;
    assign cmd_quant = quant_r;

endmodule
